// File: rtl/uge_compare_arbiter.sv
// Round-robin arbiter in front of one shared unsigned >= comparator.
// N requesters offer (a, b) operand pairs; one is granted per cycle, compared,
// and the tagged result is held in a single registered response slot that
// the consumer drains with rsp_ready.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. A requester holds valid and its operands stable
// until it transfers. req_ready is one-hot or zero and never asserts for a
// requester whose valid is low. The response slot is free when it is empty or
// being drained this cycle, so a drain and a new grant can share one edge.
module uge_compare_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int IDW   = $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_a,
  input  logic [N*WIDTH-1:0]   req_b,
  output logic [N-1:0]         req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_ge,
  input  logic                 rsp_ready,
  output logic [15:0]          op_count
);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_ge_q, rsp_ge_d;
  logic [15:0]      op_count_q, op_count_d;

  logic             hi_found, lo_found;
  logic [IDW-1:0]   hi_idx, lo_idx;
  logic             slot_free;
  logic             grant;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             cmp_ge;

  // Round-robin search: lowest valid index at or above ptr wins; otherwise the
  // lowest valid index below ptr (the wrapped-around part of the ring).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IDW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDW'(i);
        end
      end
    end
  end

  // Grant decision; reset forces ready low even though the slot reads empty.
  always_comb begin
    slot_free = !rsp_valid_q || rsp_ready;
    grant     = ASYNCRESETN && slot_free && (hi_found || lo_found);
    grant_idx = hi_found ? hi_idx : lo_idx;
    req_ready = grant ? (N'(1) << grant_idx) : '0;
  end

  // Shared comparator fed by the granted requester's operand slices.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == grant_idx) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
    cmp_ge = (a_sel >= b_sel);
  end

  // Next state: load on grant, drain on rsp_ready, otherwise hold.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_ge_d    = rsp_ge_q;
    op_count_d  = op_count_q;
    if (grant) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_ge_d    = cmp_ge;
      ptr_d       = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
      op_count_d  = (op_count_q == 16'hFFFF) ? op_count_q : op_count_q + 16'd1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_ge_q    <= 1'b0;
      op_count_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ge_q    <= rsp_ge_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ge    = rsp_ge_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_uge_compare_arbiter.sv
// Bench for uge_compare_arbiter (WIDTH=8, N=4): a reference model of the
// arbitration rules checked on every falling edge, plus directed scenarios
// with hand-computed grant orders, compare results and counter values.
module tb_uge_compare_arbiter;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int IDW   = 2;

  logic               CLK;
  logic               ASYNCRESETN;
  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [N-1:0]       req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_ge;
  logic               rsp_ready;
  logic [15:0]        op_count;

  int checks   = 0;
  int failures = 0;

  // Bench control
  bit           keep_valid = 1'b0;
  bit           log_en     = 1'b0;
  logic [N-1:0] xfer_last  = '0;
  int           gnt_q[$];

  // Model state
  int m_ptr, m_rv, m_id, m_ge, m_cnt;
  int m_g;
  int m_next_ge;

  uge_compare_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_ge     (rsp_ge),
    .rsp_ready  (rsp_ready),
    .op_count   (op_count)
  );

  // Clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Who wins: walk the ring starting at ptr; nobody if the slot is blocked.
  function automatic int pick(input int ptr, input logic [N-1:0] v,
                              input int rv, input logic rr);
    int idx;
    if (rv != 0 && !rr) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Model: expected winner and its compare result for the current inputs.
  always_comb begin
    m_g       = pick(m_ptr, req_valid, m_rv, rsp_ready);
    m_next_ge = 0;
    if (m_g >= 0)
      m_next_ge = (int'(req_a[m_g*WIDTH +: WIDTH]) >= int'(req_b[m_g*WIDTH +: WIDTH])) ? 1 : 0;
  end

  // Model: state advance at each edge.
  always @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      m_ptr <= 0;
      m_rv  <= 0;
      m_id  <= 0;
      m_ge  <= 0;
      m_cnt <= 0;
    end else if (m_g >= 0) begin
      m_rv  <= 1;
      m_id  <= m_g;
      m_ge  <= m_next_ge;
      m_ptr <= (m_g + 1) % N;
      m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else if (rsp_ready) begin
      m_rv <= 0;
    end
  end

  // Compare process: every falling edge outside reset; also records transfers.
  always @(negedge CLK) begin
    if (!ASYNCRESETN) begin
      xfer_last = '0;
    end else begin
      chk("req_ready", int'(req_ready), (m_g >= 0) ? (1 << m_g) : 0);
      chk("rsp_valid", int'(rsp_valid), m_rv);
      chk("rsp_id",    int'(rsp_id),    m_id);
      chk("rsp_ge",    int'(rsp_ge),    m_ge);
      chk("op_count",  int'(op_count),  m_cnt);
      xfer_last = req_valid & req_ready;
      if (log_en)
        for (int i = 0; i < N; i++)
          if (xfer_last[i]) gnt_q.push_back(i);
    end
  end

  // Driver tasks
  task automatic set_req(input int i, input int a, input int b);
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    req_valid[i] = 1'b1;
  endtask

  // Advance one clock; retire transferred requests or re-present new ones.
  task automatic cycle();
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (xfer_last[i]) begin
        if (keep_valid) set_req(i, $urandom_range(0, 255), $urandom_range(0, 255));
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic expect_gnt(input string name, input int exp);
    if (gnt_q.size() == 0) begin
      chk({name, "_missing"}, -1, exp);
    end else begin
      chk(name, gnt_q.pop_front(), exp);
    end
  endtask

  int cmp_a[4]  = '{5, 3, 255, 0};
  int cmp_b[4]  = '{5, 200, 0, 255};
  int cmp_ge[4] = '{1, 0, 1, 0};

  initial begin
    // Reset phase
    ASYNCRESETN = 1'b0;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b1;
    #2;
    req_valid = '1;
    #10;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_op_count",  int'(op_count),  0);
    req_valid = '0;
    #6 ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;

    // Compare values through requester 2 only
    for (int k = 0; k < 4; k++) begin
      set_req(2, cmp_a[k], cmp_b[k]);
      cycle();
      chk("cmp_valid", int'(rsp_valid), 1);
      chk("cmp_id",    int'(rsp_id),    2);
      chk("cmp_ge",    int'(rsp_ge),    cmp_ge[k]);
    end
    chk("cmp_count", int'(op_count), 4);

    // Mid-run reset pulse with a held response and op_count=5
    set_req(0, 1, 2);
    cycle();
    chk("pre_rst_valid", int'(rsp_valid), 1);
    chk("pre_rst_count", int'(op_count),  5);
    chk("pre_rst_ge",    int'(rsp_ge),    0);
    for (int i = 0; i < N; i++) set_req(i, 10 + i, 12);
    #2 ASYNCRESETN = 1'b0;
    #1;
    chk("async_rsp_valid", int'(rsp_valid), 0);
    chk("async_rsp_id",    int'(rsp_id),    0);
    chk("async_rsp_ge",    int'(rsp_ge),    0);
    chk("async_op_count",  int'(op_count),  0);
    chk("async_req_ready", int'(req_ready), 0);
    req_valid = '0;
    #2 ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;

    // Full contention for 8 cycles, pointer starting at 0
    log_en     = 1'b1;
    keep_valid = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 20 * i, 30);
    repeat (8) cycle();
    keep_valid = 1'b0;
    req_valid  = '0;
    for (int k = 0; k < 8; k++) expect_gnt("contention_order", k % 4);
    chk("contention_count", int'(op_count), 8);

    // Pointer wrap: move ptr to 2, then only 1 and 3 request
    set_req(1, 7, 7);
    cycle();
    set_req(1, 1, 2);
    set_req(3, 200, 100);
    cycle();
    cycle();
    expect_gnt("wrap_setup", 1);
    expect_gnt("wrap_first", 3);
    expect_gnt("wrap_second", 1);
    // All valid for one cycle: winner 2 shows ptr was left at 2
    set_req(0, 1, 1);
    set_req(1, 1, 1);
    set_req(2, 9, 4);
    set_req(3, 1, 1);
    cycle();
    expect_gnt("wrap_ptr_end", 2);

    // Backpressure with requesters 0 and 1 waiting
    req_valid = '0;
    rsp_ready = 1'b0;
    set_req(0, 100, 101);
    set_req(1, 101, 100);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_req_ready", int'(req_ready), 0);
      cycle();
      chk("bp_rsp_valid", int'(rsp_valid), 1);
      chk("bp_rsp_id",    int'(rsp_id),    2);
      chk("bp_rsp_ge",    int'(rsp_ge),    1);
      chk("bp_op_count",  int'(op_count),  12);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", int'(req_ready), 1);
    cycle();
    chk("bp_next_valid", int'(rsp_valid), 1);
    chk("bp_next_id",    int'(rsp_id),    0);
    chk("bp_next_ge",    int'(rsp_ge),    0);
    cycle();
    chk("bp_last_id", int'(rsp_id), 1);
    chk("bp_last_ge", int'(rsp_ge), 1);
    chk("bp_count",   int'(op_count), 14);
    expect_gnt("bp_order0", 0);
    expect_gnt("bp_order1", 1);
    log_en = 1'b0;

    // Saturation of op_count
    keep_valid = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 255), $urandom_range(0, 255));
    repeat (65520) cycle();
    chk("sat_minus1", int'(op_count), 16'hFFFE);
    cycle();
    chk("sat_reach", int'(op_count), 16'hFFFF);
    repeat (2) cycle();
    chk("sat_hold",  int'(op_count), 16'hFFFF);
    chk("sat_valid", int'(rsp_valid), 1);
    keep_valid = 1'b0;
    req_valid  = '0;
    repeat (3) cycle();
    chk("drain_valid", int'(rsp_valid), 0);
    chk("grant_log_empty", gnt_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
